fetch_ctrl: RTL and testbench

- Sequencing controller for the instruction-fetch stage of the 5-stage pipelined CPU.
- Owns the program counter and drives fetch enable, IF/ID write-enable, IF/ID flush and ID/EX bubble.
- Arbitrates branch/jump redirects, load-use stalls and the halt word (32'hFFFFFFFF, flagged in IF/ID bit 64).
- On halt it drains the pipeline, then freezes and raises done.

---
 rtl/fetch_ctrl.sv | 169 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// ============================================================================
// fetch_ctrl : instruction-fetch sequencing controller (PC, stalls, redirects,
//              halt drain).                                  Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        halt_seen,
  input  logic        load_use_hazard,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic        fetch_en,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        done,
  output logic [31:0] cycle_count,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam bit          SINGLE_STALL = (STALL_CYCLES <= 1);
  localparam logic [31:0] STALL_ENTRY  = 32'(STALL_CYCLES - 2);
  localparam logic [31:0] STALL_RELOAD = 32'(STALL_CYCLES - 1);
  localparam logic [31:0] DRAIN_LOAD   = 32'(DRAIN_CYCLES - 1);

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc_nx;
  logic [31:0] cnt;
  logic [31:0] cnt_nx;
  logic        stall_inc;
  logic        redirect;
  logic [31:0] redirect_pc;

  // Branch beats jump when both resolve together; targets are word aligned.
  assign redirect    = branch_taken | jump;
  assign redirect_pc = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= RUN;
      pc          <= RESET_PC;
      cnt         <= '0;
      cycle_count <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      cnt   <= cnt_nx;
      if (state != HALT) begin
        cycle_count <= cycle_count + 32'd1;
      end
      if (stall_inc) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    cnt_nx      = cnt;
    stall_inc   = 1'b0;
    fetch_en    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    done        = 1'b0;

    case (state)
      RUN: begin
        if (redirect) begin
          pc_nx      = redirect_pc;
          fetch_en   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          cnt_nx     = '0;
          state_nx   = RUN;
        end else if (load_use_hazard) begin
          fetch_en    = 1'b1;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
          if (!SINGLE_STALL) begin
            state_nx = STALL;
            cnt_nx   = STALL_ENTRY;
          end
        end else if (halt_seen) begin
          // Halt word moves on to EX while a NOP takes its place in ID.
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          state_nx   = DRAIN;
          cnt_nx     = DRAIN_LOAD;
        end else begin
          fetch_en   = 1'b1;
          ifid_write = 1'b1;
          pc_nx      = pc + 32'd4;
        end
      end

      STALL: begin
        if (redirect) begin
          pc_nx      = redirect_pc;
          fetch_en   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          cnt_nx     = '0;
          state_nx   = RUN;
        end else begin
          fetch_en    = 1'b1;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
          if (cnt != 32'd0) begin
            cnt_nx = cnt - 32'd1;
          end else if (load_use_hazard) begin
            cnt_nx = STALL_RELOAD;
          end else begin
            state_nx = RUN;
          end
        end
      end

      DRAIN: begin
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
        if (cnt == 32'd0) begin
          state_nx = HALT;
        end else begin
          cnt_nx = cnt - 32'd1;
        end
      end

      HALT: begin
        done = 1'b1;
      end

      default: begin
        state_nx = RUN;
      end
    endcase

    // Reset forces a flushed, idle front end without waiting for a clock.
    if (!RESET_N) begin
      fetch_en    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b0;
      done        = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// tb_fetch_ctrl : scoreboard bench for fetch_ctrl (STALL_CYCLES=1 and 3).
//                                                            Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

  typedef struct {
    int          id;
    logic        sel;
    logic [31:0] pc;
    logic [3:0]  ctl;
    logic        done;
    logic [31:0] cc;
    logic [31:0] sc;
  } exp_t;

  // ctl = {fetch_en, ifid_write, ifid_flush, idex_bubble}
  localparam logic [3:0] K_RUN = 4'b1100;
  localparam logic [3:0] K_BUB = 4'b1001;
  localparam logic [3:0] K_RED = 4'b1110;
  localparam logic [3:0] K_DRN = 4'b0110;
  localparam logic [3:0] K_HLT = 4'b0000;
  localparam logic [3:0] K_RST = 4'b0010;
  // ev = {load_use_hazard, halt_seen, branch_taken, jump}
  localparam logic [3:0] E_N  = 4'b0000;
  localparam logic [3:0] E_HZ = 4'b1000;
  localparam logic [3:0] E_HL = 4'b0100;
  localparam logic [3:0] E_BR = 4'b0010;
  localparam logic [3:0] E_JP = 4'b0001;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        rst_b = 1'b0;
  logic        halt_seen = 1'b0;
  logic        load_use_hazard = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;

  logic [31:0] pc_a, cc_a, sc_a, pc_b, cc_b, sc_b;
  logic        fe_a, wr_a, fl_a, bub_a, done_a;
  logic        fe_b, wr_b, fl_b, bub_b, done_b;

  exp_t q[$];
  logic sel_g = 1'b0;
  int   vec_id = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0), .STALL_CYCLES(1), .DRAIN_CYCLES(4)) u_dut_a (
    .CLK(clk), .RESET_N(rst_a), .halt_seen(halt_seen), .load_use_hazard(load_use_hazard),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .pc(pc_a), .fetch_en(fe_a), .ifid_write(wr_a),
    .ifid_flush(fl_a), .idex_bubble(bub_a), .done(done_a), .cycle_count(cc_a),
    .stall_count(sc_a)
  );

  fetch_ctrl #(.RESET_PC(32'h0), .STALL_CYCLES(3), .DRAIN_CYCLES(4)) u_dut_b (
    .CLK(clk), .RESET_N(rst_b), .halt_seen(halt_seen), .load_use_hazard(load_use_hazard),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .pc(pc_b), .fetch_en(fe_b), .ifid_write(wr_b),
    .ifid_flush(fl_b), .idex_bubble(bub_b), .done(done_b), .cycle_count(cc_b),
    .stall_count(sc_b)
  );

  // Drive one cycle of stimulus just after the edge and queue its expected outputs.
  task automatic cyc(input logic ra, input logic rb, input logic [3:0] ev,
                     input logic [31:0] bt, input logic [31:0] jt,
                     input logic [31:0] epc, input logic [3:0] ectl, input logic edone,
                     input logic [31:0] ecc, input logic [31:0] esc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_a = ra;
    rst_b = rb;
    {load_use_hazard, halt_seen, branch_taken, jump} = ev;
    branch_target = bt;
    jump_target   = jt;
    e.id = vec_id; e.sel = sel_g; e.pc = epc; e.ctl = ectl;
    e.done = edone; e.cc = ecc; e.sc = esc;
    q.push_back(e);
    vec_id++;
  endtask

  // Monitor: compare the active DUT mid-cycle against the oldest expectation.
  initial begin
    exp_t        e;
    logic [31:0] apc, acc, asc;
    logic [3:0]  actl;
    logic        adone;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        apc   = e.sel ? pc_b : pc_a;
        acc   = e.sel ? cc_b : cc_a;
        asc   = e.sel ? sc_b : sc_a;
        actl  = e.sel ? {fe_b, wr_b, fl_b, bub_b} : {fe_a, wr_a, fl_a, bub_a};
        adone = e.sel ? done_b : done_a;
        n_checks++;
        if (apc !== e.pc || actl !== e.ctl || adone !== e.done || acc !== e.cc || asc !== e.sc) begin
          n_fail++;
          $display("FAIL vec%0d dut%0d: got pc=%h ctl=%b done=%b cc=%0d sc=%0d, want pc=%h ctl=%b done=%b cc=%0d sc=%0d",
                   e.id, e.sel, apc, actl, adone, acc, asc, e.pc, e.ctl, e.done, e.cc, e.sc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- DUT A: STALL_CYCLES=1 ----
    cyc(0, 0, E_N, 0, 0, 32'h0,  K_RST, 0, 0, 0);
    cyc(1, 0, E_N, 0, 0, 32'h0,  K_RUN, 0, 0, 0);
    cyc(1, 0, E_N, 0, 0, 32'h4,  K_RUN, 0, 1, 0);
    cyc(1, 0, E_N, 0, 0, 32'h8,  K_RUN, 0, 2, 0);
    cyc(1, 0, E_N, 0, 0, 32'hC,  K_RUN, 0, 3, 0);
    cyc(1, 0, E_N, 0, 0, 32'h10, K_RUN, 0, 4, 0);
    cyc(1, 0, E_N, 0, 0, 32'h14, K_RUN, 0, 5, 0);
    cyc(1, 0, E_HZ, 0, 0, 32'h18, K_BUB, 0, 6, 0);
    cyc(1, 0, E_N, 0, 0, 32'h18, K_RUN, 0, 7, 1);
    cyc(1, 0, E_N, 0, 0, 32'h1C, K_RUN, 0, 8, 1);
    cyc(1, 0, E_BR | E_JP, 32'h103, 32'h200, 32'h20, K_RED, 0, 9, 1);
    cyc(1, 0, E_N, 0, 0, 32'h100, K_RUN, 0, 10, 1);
    cyc(1, 0, E_N, 0, 0, 32'h104, K_RUN, 0, 11, 1);
    cyc(1, 0, E_HL | E_JP, 0, 32'h20, 32'h108, K_RED, 0, 12, 1);
    cyc(1, 0, E_HL, 0, 0, 32'h20, K_DRN, 0, 13, 1);
    cyc(1, 0, E_HZ | E_BR, 32'h80, 0, 32'h20, K_DRN, 0, 14, 1);
    cyc(1, 0, E_N, 0, 0, 32'h20, K_DRN, 0, 15, 1);
    cyc(1, 0, E_N, 0, 0, 32'h20, K_DRN, 0, 16, 1);
    cyc(1, 0, E_N, 0, 0, 32'h20, K_DRN, 0, 17, 1);
    cyc(1, 0, E_BR, 32'h80, 0, 32'h20, K_HLT, 1, 18, 1);
    cyc(1, 0, E_N, 0, 0, 32'h20, K_HLT, 1, 18, 1);
    cyc(0, 0, E_N, 0, 0, 32'h0,  K_RST, 0, 0, 0);
    cyc(1, 0, E_N, 0, 0, 32'h0,  K_RUN, 0, 0, 0);
    cyc(1, 0, E_HL, 0, 0, 32'h4, K_DRN, 0, 1, 0);
    cyc(1, 0, E_N, 0, 0, 32'h4,  K_DRN, 0, 2, 0);
    cyc(0, 0, E_N, 0, 0, 32'h0,  K_RST, 0, 0, 0);
    cyc(1, 0, E_N, 0, 0, 32'h0,  K_RUN, 0, 0, 0);
    cyc(1, 0, E_N, 0, 0, 32'h4,  K_RUN, 0, 1, 0);
    cyc(1, 0, E_JP, 0, 32'hFFFF_FFFF, 32'h8, K_RED, 0, 2, 0);
    cyc(1, 0, E_N, 0, 0, 32'hFFFF_FFFC, K_RUN, 0, 3, 0);
    cyc(1, 0, E_N, 0, 0, 32'h0,  K_RUN, 0, 4, 0);
    // ---- DUT B: STALL_CYCLES=3 ----
    sel_g = 1'b1;
    cyc(0, 0, E_N, 0, 0, 32'h0,  K_RST, 0, 0, 0);
    cyc(0, 1, E_N, 0, 0, 32'h0,  K_RUN, 0, 0, 0);
    cyc(0, 1, E_N, 0, 0, 32'h4,  K_RUN, 0, 1, 0);
    cyc(0, 1, E_HZ, 0, 0, 32'h8, K_BUB, 0, 2, 0);
    cyc(0, 1, E_N, 0, 0, 32'h8,  K_BUB, 0, 3, 1);
    cyc(0, 1, E_N, 0, 0, 32'h8,  K_BUB, 0, 4, 2);
    cyc(0, 1, E_N, 0, 0, 32'h8,  K_RUN, 0, 5, 3);
    cyc(0, 1, E_N, 0, 0, 32'hC,  K_RUN, 0, 6, 3);
    cyc(0, 1, E_HZ, 0, 0, 32'h10, K_BUB, 0, 7, 3);
    cyc(0, 1, E_BR, 32'h40, 0, 32'h10, K_RED, 0, 8, 4);
    cyc(0, 1, E_N, 0, 0, 32'h40, K_RUN, 0, 9, 4);
    cyc(0, 1, E_N, 0, 0, 32'h44, K_RUN, 0, 10, 4);
    cyc(0, 1, E_HZ, 0, 0, 32'h48, K_BUB, 0, 11, 4);
    cyc(0, 1, E_HZ | E_HL, 0, 0, 32'h48, K_BUB, 0, 12, 5);
    cyc(0, 1, E_HZ, 0, 0, 32'h48, K_BUB, 0, 13, 6);
    cyc(0, 1, E_HL, 0, 0, 32'h48, K_BUB, 0, 14, 7);
    cyc(0, 1, E_N, 0, 0, 32'h48, K_BUB, 0, 15, 8);
    cyc(0, 1, E_N, 0, 0, 32'h48, K_BUB, 0, 16, 9);
    cyc(0, 1, E_N, 0, 0, 32'h48, K_RUN, 0, 17, 10);
    cyc(0, 1, E_N, 0, 0, 32'h4C, K_RUN, 0, 18, 10);

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
